alarm_buzzer_seq: RTL and testbench

//   Downstream stage of the alarm-time compare in the VGA clock top level.
//   It turns the level "alarm time reached" into a beeping buzzer pattern,

---
 rtl/alarm_buzzer_seq.sv | 114 +++++++++++
 tb/tb_alarm_buzzer_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/alarm_buzzer_seq.sv
// alarm_buzzer_seq: turns alarm_match into a beeping buzzer with stop, snooze and auto-timeout; define BUZZER_ESCALATE_EN for a continuous tone after ESCALATE_CYCLES beep cycles
module alarm_buzzer_seq #(
  parameter int BEEP_ON_TICKS      = 50,
  parameter int BEEP_OFF_TICKS     = 50,
  parameter int RING_TIMEOUT_TICKS = 6000,
  parameter int SNOOZE_TICKS       = 30000,
  parameter int MAX_SNOOZES        = 3,
  parameter int ESCALATE_CYCLES    = 10
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               i_tick_100hz,
  input  logic                               i_tone_pulse,
  input  logic                               i_al_enable,
  input  logic                               i_alarm_match,
  input  logic                               i_stop_pulse,
  input  logic                               i_snooze_pulse,
  output logic                               o_buzzer_out,
  output logic                               o_ringing,
  output logic                               o_snoozing,
  output logic [$clog2(MAX_SNOOZES+1)-1:0]   o_snooze_cnt
);
  localparam int PMAX = (BEEP_ON_TICKS > BEEP_OFF_TICKS) ? BEEP_ON_TICKS : BEEP_OFF_TICKS;
  localparam int PW = $clog2(PMAX + 1);
  localparam int TW = $clog2(RING_TIMEOUT_TICKS + 1);
  localparam int SW = $clog2(SNOOZE_TICKS + 1);
  localparam int CW = $clog2(MAX_SNOOZES + 1);
  localparam logic [PW-1:0] PON_LAST  = PW'(BEEP_ON_TICKS - 1);
  localparam logic [PW-1:0] POFF_LAST = PW'(BEEP_OFF_TICKS - 1);
  localparam logic [TW-1:0] T_LAST    = TW'(RING_TIMEOUT_TICKS - 1);
  localparam logic [SW-1:0] S_LAST    = SW'(SNOOZE_TICKS - 1);
  localparam logic [CW-1:0] SC_MAX    = CW'(MAX_SNOOZES);

  typedef enum logic [2:0] {IDLE, RING_ON, RING_OFF, SNOOZE, DONE} state_t;

  state_t        r_state, w_next;
  logic [PW-1:0] r_phase;
  logic [TW-1:0] r_tmo;
  logic [SW-1:0] r_snz;
  logic [CW-1:0] r_sc;
  logic          r_tone, r_buzzer, r_ringing, r_snoozing;
  logic          w_ring, w_next_ring, w_phase_done, w_tmo_done, w_snz_done, w_snz_ok, w_escalated;

  assign w_ring       = (r_state == RING_ON) || (r_state == RING_OFF);
  assign w_next_ring  = (w_next == RING_ON) || (w_next == RING_OFF);
  assign w_phase_done = i_tick_100hz && (r_phase == ((r_state == RING_ON) ? PON_LAST : POFF_LAST));
  assign w_tmo_done   = i_tick_100hz && w_ring && (r_tmo == T_LAST);
  assign w_snz_done   = i_tick_100hz && (r_state == SNOOZE) && (r_snz == S_LAST);
  assign w_snz_ok     = i_snooze_pulse && w_ring && (r_sc < SC_MAX);

`ifdef BUZZER_ESCALATE_EN
  localparam int EW = $clog2(ESCALATE_CYCLES + 1);
  localparam logic [EW-1:0] E_LAST = EW'(ESCALATE_CYCLES);
  logic [EW-1:0] r_cyc;
  assign w_escalated = r_cyc == E_LAST;
  // count completed ON+OFF cycles of the current ring burst; any non-ringing state restarts it
  always_ff @(posedge clk)
    if (reset || !w_ring) r_cyc <= '0;
    else if (r_state == RING_OFF && w_next == RING_ON) r_cyc <= r_cyc + EW'(1);
`else
  assign w_escalated = 1'b0;
`endif

  // next state: timers lowest, then snooze, stop and disarm override in rising priority
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = i_alarm_match ? RING_ON : IDLE;
      RING_ON:  w_next = w_tmo_done ? DONE : (w_phase_done && !w_escalated) ? RING_OFF : RING_ON;
      RING_OFF: w_next = w_tmo_done ? DONE : w_phase_done ? RING_ON : RING_OFF;
      SNOOZE:   w_next = w_snz_done ? RING_ON : SNOOZE;
      DONE:     w_next = i_alarm_match ? DONE : IDLE;
      default:  w_next = IDLE;
    endcase
    if (w_snz_ok) w_next = SNOOZE;
    if (i_stop_pulse && (w_ring || r_state == SNOOZE)) w_next = DONE;
    if (!i_al_enable) w_next = IDLE;
  end

  // state register plus outputs registered from the next state; tone restarts at 0 for every beep
  always_ff @(posedge clk)
    if (reset) begin
      r_state    <= IDLE;
      r_ringing  <= 1'b0;
      r_snoozing <= 1'b0;
      r_tone     <= 1'b0;
      r_buzzer   <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_ringing  <= w_next_ring;
      r_snoozing <= w_next == SNOOZE;
      r_tone     <= (w_next == RING_ON) && (r_tone ^ i_tone_pulse);
      r_buzzer   <= (w_next == RING_ON) && r_tone;
    end

  // phase, timeout, snooze-length and snooze-count counters, each cleared on its terminal event
  always_ff @(posedge clk)
    if (reset) begin
      r_phase <= '0;
      r_tmo   <= '0;
      r_snz   <= '0;
      r_sc    <= '0;
    end else begin
      r_phase <= (!w_ring || w_next != r_state || w_phase_done) ? '0 : r_phase + PW'(i_tick_100hz);
      r_tmo   <= (w_ring && w_next_ring) ? r_tmo + TW'(i_tick_100hz) : '0;
      r_snz   <= (r_state == SNOOZE && w_next == SNOOZE) ? r_snz + SW'(i_tick_100hz) : '0;
      r_sc    <= (r_state == IDLE || w_next == IDLE) ? '0 : r_sc + CW'(w_ring && w_next == SNOOZE);
    end

  assign o_buzzer_out = r_buzzer;
  assign o_ringing    = r_ringing;
  assign o_snoozing   = r_snoozing;
  assign o_snooze_cnt = r_sc;
endmodule

// File: tb/tb_alarm_buzzer_seq.sv
// tb_alarm_buzzer_seq: directed vectors for alarm_buzzer_seq with ON=3 OFF=2 TIMEOUT=20 SNOOZE=10 MAX_SNOOZES=2 ESCALATE_CYCLES=2
module tb_alarm_buzzer_seq;
`ifdef BUZZER_ESCALATE_EN
  localparam logic ESC = 1'b1;
`else
  localparam logic ESC = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1;
  logic en = 1'b0, match = 1'b0, stop = 1'b0, snz = 1'b0, tick = 1'b0, tone = 1'b0;
  logic buz, ring, sng;
  logic [1:0] cnt;
  int n_pass = 0, n_total = 0;
  typedef struct { logic [5:0] in; logic [4:0] exp; } vec_t;
  vec_t vecs[14];

  always #5 clk = ~clk;

  alarm_buzzer_seq #(
    .BEEP_ON_TICKS(3), .BEEP_OFF_TICKS(2), .RING_TIMEOUT_TICKS(20),
    .SNOOZE_TICKS(10), .MAX_SNOOZES(2), .ESCALATE_CYCLES(2)
  ) dut (
    .clk(clk), .reset(reset), .i_tick_100hz(tick), .i_tone_pulse(tone),
    .i_al_enable(en), .i_alarm_match(match), .i_stop_pulse(stop), .i_snooze_pulse(snz),
    .o_buzzer_out(buz), .o_ringing(ring), .o_snoozing(sng), .o_snooze_cnt(cnt)
  );

  task automatic cyc(input logic [5:0] v);
    {en, match, stop, snz, tick, tone} = v;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [4:0] e);
    n_total++;
    if ({buz, ring, sng, cnt} === e) n_pass++;
    else $display("FAIL %s: buz/ring/snoozing/cnt got %b want %b", name, {buz, ring, sng, cnt}, e);
  endtask

  task automatic snooze_run(input logic [1:0] c);
    for (int k = 1; k <= 10; k++) begin
      cyc(6'b100010);
      chk($sformatf("snooze_tick%0d", k), {1'b0, k == 10, k < 10, c});
    end
  endtask

  initial begin
    vecs[0]  = '{6'b110000, 5'b01000};
    vecs[1]  = '{6'b110001, 5'b01000};
    vecs[2]  = '{6'b110000, 5'b11000};
    vecs[3]  = '{6'b110001, 5'b11000};
    vecs[4]  = '{6'b110000, 5'b01000};
    vecs[5]  = '{6'b110010, 5'b01000};
    vecs[6]  = '{6'b110010, 5'b01000};
    vecs[7]  = '{6'b110001, 5'b01000};
    vecs[8]  = '{6'b110010, 5'b01000};
    vecs[9]  = '{6'b110001, 5'b01000};
    vecs[10] = '{6'b110010, 5'b01000};
    vecs[11] = '{6'b110010, 5'b01000};
    vecs[12] = '{6'b110001, 5'b01000};
    vecs[13] = '{6'b110000, 5'b11000};

    reset = 1'b1;
    cyc(6'b000000);
    cyc(6'b000000);
    chk("reset", 5'b00000);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      cyc(vecs[i].in);
      chk($sformatf("vec%0d", i), vecs[i].exp);
    end

    for (int k = 6; k <= 20; k++) begin
      cyc(6'b110010);
      chk($sformatf("timeout_tick%0d", k), {k < 8, k < 20, 3'b000});
    end
    for (int k = 0; k < 4; k++) begin
      cyc(6'b110010);
      chk("done_hold", 5'b00000);
    end
    cyc(6'b100000);
    chk("done_to_idle", 5'b00000);
    cyc(6'b110000);
    chk("retrigger", 5'b01000);

    cyc(6'b110100);
    chk("snooze1", 5'b00101);
    snooze_run(2'd1);
    cyc(6'b110100);
    chk("snooze2", 5'b00110);
    snooze_run(2'd2);
    cyc(6'b110100);
    chk("snooze_limit", 5'b01010);
    for (int k = 1; k <= 20; k++) begin
      cyc(6'b110010);
      chk($sformatf("post_snooze_tick%0d", k), {1'b0, k < 20, 3'b010});
    end
    cyc(6'b110000);
    chk("done_keeps_cnt", 5'b00010);
    cyc(6'b100000);
    chk("idle_clears_cnt", 5'b00000);

    cyc(6'b110000);
    chk("ring4", 5'b01000);
    cyc(6'b110100);
    chk("snooze4", 5'b00101);
    snooze_run(2'd1);
    cyc(6'b111100);
    chk("stop_beats_snooze", 5'b00001);
    for (int k = 0; k < 3; k++) begin
      cyc(6'b110000);
      chk("no_reret", 5'b00001);
    end
    cyc(6'b100000);
    chk("idle4", 5'b00000);
    cyc(6'b110000);
    chk("ring4b", 5'b01000);
    cyc(6'b110100);
    chk("snooze4b", 5'b00101);
    cyc(6'b111000);
    chk("stop_in_snooze", 5'b00001);
    cyc(6'b100000);
    chk("idle4b", 5'b00000);

    cyc(6'b110000);
    chk("ring5", 5'b01000);
    cyc(6'b110001);
    chk("tone5", 5'b01000);
    cyc(6'b110000);
    chk("buz5", 5'b11000);
    cyc(6'b010000);
    chk("disarm_ring", 5'b00000);
    cyc(6'b110000);
    chk("rearm_ring", 5'b01000);
    cyc(6'b110100);
    chk("snooze5", 5'b00101);
    cyc(6'b010000);
    chk("disarm_snooze", 5'b00000);
    cyc(6'b100000);
    chk("idle5", 5'b00000);

    cyc(6'b110000);
    chk("ring_esc", 5'b01000);
    for (int k = 1; k <= 13; k++) begin
      cyc(6'b110010);
      chk($sformatf("esc_tick%0d", k), 5'b01000);
    end
    cyc(6'b110001);
    chk("esc_tone", 5'b01000);
    cyc(6'b110000);
    chk("esc_buz", {ESC, 4'b1000});
    for (int k = 14; k <= 20; k++) begin
      cyc(6'b110010);
      chk($sformatf("esc_tick%0d", k), {ESC && k < 20, k < 20, 3'b000});
    end
    cyc(6'b100000);
    chk("idle_esc", 5'b00000);

    cyc(6'b110000);
    chk("ring6", 5'b01000);
    cyc(6'b110001);
    chk("tone6", 5'b01000);
    cyc(6'b110000);
    chk("buz6", 5'b11000);
    reset = 1'b1;
    cyc(6'b110000);
    chk("reset_mid_ring", 5'b00000);
    reset = 1'b0;
    cyc(6'b110000);
    chk("ring_after_reset", 5'b01000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
